// File: rtl/mcu_pkg.sv
// Shared types and constants for the mcu_processor accumulator core.
// Optional HALT behaviour is selected by the MCU_HALT_EN macro in the top level.
package mcu_pkg;

    localparam int DATA_W = 8;
    localparam int NREGS  = 16;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LDI   = 4'h1,
        OP_LDH   = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_ST    = 4'h8,
        OP_LD    = 4'h9,
        OP_ADDI  = 4'hA,
        OP_UNARY = 4'hB,
        OP_JMP   = 4'hC,
        OP_JZ    = 4'hD,
        OP_JC    = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    localparam logic [1:0] UOP_SHL = 2'd0;
    localparam logic [1:0] UOP_SHR = 2'd1;
    localparam logic [1:0] UOP_NOT = 2'd2;
    localparam logic [1:0] UOP_CLR = 2'd3;

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_e;

    // Immediate operand ops take the zero-extended low nibble instead of R[n].
    function automatic logic uses_imm(input opcode_e op);
        return (op == OP_LDI) || (op == OP_LDH) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mcu_alu.sv
// Combinational ALU: computes the new accumulator value and carry for one opcode.
module mcu_alu
    import mcu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  opcode_e        op_i,
    input  logic [1:0]     sub_op_i,
    input  logic [W-1:0]   acc_i,
    input  logic [W-1:0]   operand_i,
    output logic [W-1:0]   result_o,
    output logic           carry_o,
    output logic           carry_we_o,
    output logic           acc_we_o
);

    logic [W:0] sum_s;

    assign sum_s = {1'b0, acc_i} + {1'b0, operand_i};

    // Opcode decode into result, carry and write strobes.
    always_comb begin
        result_o   = acc_i;
        carry_o    = 1'b0;
        carry_we_o = 1'b0;
        acc_we_o   = 1'b0;
        case (op_i)
            OP_LDI, OP_LD: begin
                result_o = operand_i;
                acc_we_o = 1'b1;
            end
            OP_LDH: begin
                result_o = {operand_i[3:0], acc_i[W-5:0]};
                acc_we_o = 1'b1;
            end
            OP_ADD, OP_ADDI: begin
                result_o   = sum_s[W-1:0];
                carry_o    = sum_s[W];
                carry_we_o = 1'b1;
                acc_we_o   = 1'b1;
            end
            OP_SUB: begin
                result_o   = acc_i - operand_i;
                carry_o    = (acc_i < operand_i);
                carry_we_o = 1'b1;
                acc_we_o   = 1'b1;
            end
            OP_AND: begin
                result_o = acc_i & operand_i;
                acc_we_o = 1'b1;
            end
            OP_OR: begin
                result_o = acc_i | operand_i;
                acc_we_o = 1'b1;
            end
            OP_XOR: begin
                result_o = acc_i ^ operand_i;
                acc_we_o = 1'b1;
            end
            OP_UNARY: begin
                acc_we_o = 1'b1;
                case (sub_op_i)
                    UOP_SHL: begin
                        result_o   = {acc_i[W-2:0], 1'b0};
                        carry_o    = acc_i[W-1];
                        carry_we_o = 1'b1;
                    end
                    UOP_SHR: begin
                        result_o   = {1'b0, acc_i[W-1:1]};
                        carry_o    = acc_i[0];
                        carry_we_o = 1'b1;
                    end
                    UOP_NOT: result_o = ~acc_i;
                    UOP_CLR: result_o = {W{1'b0}};
                    default: result_o = acc_i;
                endcase
            end
            default: result_o = acc_i;
        endcase
    end

endmodule

// File: rtl/mcu_processor.sv
// 8-bit accumulator core: two-cycle FETCH/EXEC sequencer, 16-entry register file, PC.
// Define MCU_HALT_EN to make opcode 0xF freeze the core until reset; otherwise it is a NOP.
module mcu_processor #(
    parameter int DATA_W = mcu_pkg::DATA_W,
    parameter int NREGS  = mcu_pkg::NREGS
) (
    input  logic              clk,
    input  logic              clb,
    input  logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] acc
);

    import mcu_pkg::*;

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic              halted_q, halted_d;
    phase_e            phase_q, phase_d;
    logic [DATA_W-1:0] rf_q [NREGS];

    opcode_e           op_s;
    logic [3:0]        n_s;
    logic [DATA_W-1:0] rf_rd_s;
    logic [DATA_W-1:0] operand_s;
    logic [DATA_W-1:0] pc_inc_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              alu_carry_s;
    logic              alu_carry_we_s;
    logic              alu_acc_we_s;
    logic              rf_we_s;

    assign op_s      = opcode_e'(ir_q[7:4]);
    assign n_s       = ir_q[3:0];
    assign rf_rd_s   = rf_q[n_s];
    assign operand_s = uses_imm(op_s) ? {{(DATA_W-4){1'b0}}, n_s} : rf_rd_s;
    assign pc_inc_s  = pc_q + {{(DATA_W-1){1'b0}}, 1'b1};

    mcu_alu #(.W(DATA_W)) u_alu (
        .op_i       (op_s),
        .sub_op_i   (n_s[1:0]),
        .acc_i      (acc_q),
        .operand_i  (operand_s),
        .result_o   (alu_result_s),
        .carry_o    (alu_carry_s),
        .carry_we_o (alu_carry_we_s),
        .acc_we_o   (alu_acc_we_s)
    );

    // Next-state: latch IR in FETCH, commit ALU/flags/PC/register write in EXEC.
    always_comb begin
        pc_d     = pc_q;
        acc_d    = acc_q;
        ir_d     = ir_q;
        c_d      = c_q;
        z_d      = z_q;
        halted_d = halted_q;
        phase_d  = phase_q;
        rf_we_s  = 1'b0;
        if (halted_q) begin
            phase_d = PH_FETCH;
        end else if (phase_q == PH_FETCH) begin
            ir_d    = instruction;
            phase_d = PH_EXEC;
        end else begin
            phase_d = PH_FETCH;
            pc_d    = pc_inc_s;
            if (alu_acc_we_s) begin
                acc_d = alu_result_s;
                z_d   = (alu_result_s == {DATA_W{1'b0}});
            end else begin
                acc_d = acc_q;
            end
            if (alu_carry_we_s) begin
                c_d = alu_carry_s;
            end else begin
                c_d = c_q;
            end
            // Branch conditions use the flags as they stood before this EXEC.
            case (op_s)
                OP_ST:  rf_we_s = 1'b1;
                OP_JMP: pc_d    = rf_rd_s;
                OP_JZ:  pc_d    = z_q ? rf_rd_s : pc_inc_s;
                OP_JC:  pc_d    = c_q ? rf_rd_s : pc_inc_s;
`ifdef MCU_HALT_EN
                OP_HALT: begin
                    halted_d = 1'b1;
                    pc_d     = pc_q;
                end
`endif
                default: rf_we_s = 1'b0;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clb) begin
            pc_q     <= {DATA_W{1'b0}};
            acc_q    <= {DATA_W{1'b0}};
            ir_q     <= {DATA_W{1'b0}};
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            halted_q <= 1'b0;
            phase_q  <= PH_FETCH;
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            ir_q     <= ir_d;
            c_q      <= c_d;
            z_q      <= z_d;
            halted_q <= halted_d;
            phase_q  <= phase_d;
            if (rf_we_s) begin
                rf_q[n_s] <= acc_q;
            end
        end
    end

    assign pc  = pc_q;
    assign acc = acc_q;

endmodule

// File: tb/tb_mcu_processor.sv
// Self-checking bench for mcu_processor: directed programs plus random programs
// checked against an instruction-level reference model of the ISA.
module tb_mcu_processor;

    logic       clk = 1'b0;
    logic       clb = 1'b0;
    logic [7:0] instr;
    logic [7:0] pc;
    logic [7:0] acc;
    logic [7:0] imem [256];

    int tests_run    = 0;
    int tests_failed = 0;

    int m_pc, m_acc;
    bit m_c, m_z, m_halt;
    int m_r [16];

    assign instr = imem[pc];

    mcu_processor dut (
        .clk         (clk),
        .clb         (clb),
        .instruction (instr),
        .pc          (pc),
        .acc         (acc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    endtask

    task automatic reset_model();
        m_pc = 0; m_acc = 0; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0;
        for (int i = 0; i < 16; i++) m_r[i] = 0;
    endtask

    task automatic do_reset(input int cycles);
        clb = 1'b0;
        repeat (cycles) step();
        clb = 1'b1;
        reset_model();
    endtask

    // One architectural instruction of the reference model.
    task automatic model_exec();
        int ins, op, n, rv, s;
        bit wr, jump;
        if (m_halt) return;
        ins = imem[m_pc];
        op = ins / 16; n = ins % 16; rv = m_r[n];
        wr = 1'b1; jump = 1'b0;
        case (op)
            0:  wr = 1'b0;
            1:  m_acc = n;
            2:  m_acc = n * 16 + m_acc % 16;
            3:  begin s = m_acc + rv; m_c = (s > 255); m_acc = s % 256; end
            4:  begin m_c = (m_acc < rv); m_acc = (m_acc - rv + 256) % 256; end
            5:  m_acc = m_acc & rv;
            6:  m_acc = m_acc | rv;
            7:  m_acc = m_acc ^ rv;
            8:  begin m_r[n] = m_acc; wr = 1'b0; end
            9:  m_acc = rv;
            10: begin s = m_acc + n; m_c = (s > 255); m_acc = s % 256; end
            11: case (n % 4)
                    0: begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; end
                    1: begin m_c = (m_acc % 2 == 1); m_acc = m_acc / 2; end
                    2: m_acc = 255 - m_acc;
                    default: m_acc = 0;
                endcase
            12: begin m_pc = rv; jump = 1'b1; wr = 1'b0; end
            13: begin if (m_z) begin m_pc = rv; jump = 1'b1; end wr = 1'b0; end
            14: begin if (m_c) begin m_pc = rv; jump = 1'b1; end wr = 1'b0; end
            default: begin
                wr = 1'b0;
`ifdef MCU_HALT_EN
                m_halt = 1'b1;
                jump = 1'b1;
`endif
            end
        endcase
        if (wr) m_z = (m_acc == 0);
        if (!jump) m_pc = (m_pc + 1) % 256;
    endtask

    // Two clocks per instruction; pc/acc must hold through the FETCH edge.
    task automatic run_instr(input string tag);
        logic [15:0] hold;
        hold = {8'(m_pc), 8'(m_acc)};
        step();
        check({tag, "/hold"}, {pc, acc}, hold);
        model_exec();
        step();
        check(tag, {pc, acc}, {8'(m_pc), 8'(m_acc)});
    endtask

    initial begin
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h0A; exp_seq[1] = 8'h0A; exp_seq[2] = 8'h05; exp_seq[3] = 8'h0F;
        clear_imem();

        // Reset hold and first instruction timing
        do_reset(3);
        check("reset_pc", {8'h00, pc}, 16'h0000);
        check("reset_acc", {8'h00, acc}, 16'h0000);
        step();
        check("first_fetch_pc", {8'h00, pc}, 16'h0000);
        step();
        check("first_exec_pc", {8'h00, pc}, 16'h0001);

        // Load/ALU program
        imem[0] = 8'h1A; imem[1] = 8'h80; imem[2] = 8'h15; imem[3] = 8'h30;
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            run_instr("ldalu");
            check("ldalu_const", {8'h00, acc}, {8'h00, exp_seq[i]});
        end

        // Reset mid-run while acc=0x0F, then identical replay
        do_reset(2);
        check("midrst_pc", {8'h00, pc}, 16'h0000);
        check("midrst_acc", {8'h00, acc}, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            run_instr("replay");
            check("replay_const", {8'h00, acc}, {8'h00, exp_seq[i]});
        end

        // Reset in EXEC phase aborts ADD and clears the register file
        do_reset(1);
        run_instr("abort_ldi");
        run_instr("abort_st");
        run_instr("abort_ldi2");
        step();
        clb = 1'b0;
        step();
        clb = 1'b1;
        reset_model();
        check("abort_state", {pc, acc}, 16'h0000);
        imem[0] = 8'h90;
        run_instr("abort_ld_r0");
        check("abort_r0_clear", {8'h00, acc}, 16'h0000);

        // Carry/wrap: 0xFF + 1 -> 0, C=1, Z=1; JC then JZ taken to 0x10
        clear_imem();
        imem[0] = 8'h10; imem[1] = 8'h21; imem[2] = 8'h81; imem[3] = 8'h1F;
        imem[4] = 8'h2F; imem[5] = 8'hA1; imem[6] = 8'hE1; imem[8'h10] = 8'hD1;
        do_reset(1);
        for (int i = 0; i < 5; i++) run_instr("carry_prep");
        check("build_ff", {8'h00, acc}, 16'h00FF);
        run_instr("addi_wrap");
        check("addi_wrap_acc", {8'h00, acc}, 16'h0000);
        run_instr("jc_taken");
        check("jc_pc", {8'h00, pc}, 16'h0010);
        run_instr("jz_taken");
        check("jz_pc", {8'h00, pc}, 16'h0010);

        // JMP to 0xFF, NOP at 0xFF wraps pc to 0x00
        clear_imem();
        imem[0] = 8'h1F; imem[1] = 8'h2F; imem[2] = 8'h82; imem[3] = 8'hC2;
        do_reset(1);
        for (int i = 0; i < 4; i++) run_instr("jmp_prep");
        check("jmp_pc", {8'h00, pc}, 16'h00FF);
        run_instr("pc_wrap");
        check("pc_wrap_const", {8'h00, pc}, 16'h0000);

        // HALT at pc 0x04
        clear_imem();
        imem[0] = 8'h13; imem[1] = 8'h80; imem[4] = 8'hF0;
        do_reset(1);
        for (int i = 0; i < 5; i++) run_instr("halt_prog");
`ifdef MCU_HALT_EN
        repeat (20) step();
        check("halt_pc", {8'h00, pc}, 16'h0004);
        check("halt_acc", {8'h00, acc}, 16'h0003);
`else
        check("halt_nop_pc", {8'h00, pc}, 16'h0005);
        check("halt_nop_acc", {8'h00, acc}, 16'h0003);
`endif

        // Random programs against the reference model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) imem[i] = 8'($urandom_range(0, 255));
            do_reset(1 + r % 2);
            for (int k = 0; k < 80; k++) run_instr("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mcu_processor.md
# mcu_processor

8-bit accumulator microcontroller core (module `mcu_processor`). It fetches one instruction per two clock cycles from an external, combinationally read instruction memory addressed by `pc`. It executes the instruction against an accumulator and a 16-entry register file, and exposes `pc` and `acc` for system observation.

## Interface
- `DATA_W`, 8: width of accumulator, registers, instruction and PC.
- `NREGS`, 16: register-file depth, indexed by instruction low nibble.
- `clk`  in  1: single clock; all state updates on rising edge.
- `clb`  in  1: reset, synchronous and active-low; sampled on rising `clk`.
- `instruction`  in  8: instruction byte at address `pc`; must be valid combinationally while `pc` is stable.
- `pc`  out  8: program counter, registered.
- `acc`  out  8: accumulator, registered.

## Operation
- Instruction format: `op = instruction[7:4]`, `n = instruction[3:0]`. `R[n]` is a register; `n` zero-extended is an immediate.
- Two-phase FSM: FETCH (latch `instruction` into IR) -> EXEC (execute IR, update `acc`, `R`, flags and `pc`) -> FETCH.
- Opcodes:
  - 0x0 NOP.
  - 0x1 LDI: acc={0,n}.
  - 0x2 LDH: acc[7:4]=n.
  - 0x3 ADD: acc+=R[n].
  - 0x4 SUB: acc-=R[n].
  - 0x5 AND, 0x6 OR, 0x7 XOR: acc op= R[n].
  - 0x8 ST: R[n]=acc.
  - 0x9 LD: acc=R[n].
  - 0xA ADDI: acc+=n.
  - 0xB unary, selected by n[1:0]: 0 SHL, 1 SHR (logical), 2 NOT, 3 CLR.
  - 0xC JMP: pc=R[n].
  - 0xD JZ: if Z then pc=R[n].
  - 0xE JC: if C then pc=R[n].
  - 0xF HALT (see Configuration).
- Flags:
  - C is updated only by ADD/ADDI (carry out of bit 7), SUB (borrow, i.e. 1 when acc<R[n]) and SHL/SHR (bit shifted out).
  - Z is updated by every instruction that writes `acc`; Z=(new acc==0).
- Arithmetic is modulo 256.
- `pc` increments by 1 after each non-taken EXEC and wraps 0xFF->0x00.
- ST followed by LD of the same register returns the stored value. No hazards exist, because EXEC fully completes before the next FETCH.

## Timing
- When `clb`=0 at a rising edge:
  - `pc`=0x00, `acc`=0x00, C=Z=0, IR=0x00.
  - All R cleared to 0x00.
  - Phase returns to FETCH; halted state clears.
- First FETCH occurs on the first rising edge with `clb`=1.
- Each instruction takes exactly 2 cycles. `pc` and `acc` change only on the EXEC edge, so both are stable for 2 cycles.
- Reset asserted mid-instruction (in either phase) aborts it; no partial writes occur.
- A jump target is fetched in the FETCH cycle immediately after the jump's EXEC.

## Configuration
- `MCU_HALT_EN` defined: opcode 0xF sets a halted state. `pc`, `acc`, R and flags then freeze until reset; the FSM stays idle.
- `MCU_HALT_EN` undefined: 0xF executes as NOP (`pc` increments).

## Structure
- Package `mcu_pkg`:
  - opcode enum (OP_NOP..OP_HALT);
  - unary sub-op constants;
  - phase enum (PH_FETCH, PH_EXEC);
  - `DATA_W`/`NREGS` constants.
- Sub-module `mcu_alu`: combinational; inputs op, sub-op, acc, operand; outputs result, carry, write-enable.
- Sequencing, register file and PC logic live in the top level.

## Test plan
- Reset: hold `clb`=0 for 3 cycles -> `pc`=0x00, `acc`=0x00; after release, `pc`=0x01 two cycles later.
- Load/ALU: program 0x1A (LDI 10), 0x80 (ST R0), 0x15 (LDI 5), 0x30 (ADD R0) -> `acc` sequence 0x0A, 0x0A, 0x05, 0x0F, with each value holding 2 cycles.
- Carry/wrap: build 0xFF via 0x1F then 0x2F, then ADDI 1 (0xA1) -> `acc`=0x00, Z=1, C=1; a following JC taken to R[n]=0x10 -> `pc`=0x10.
- Jump and PC wrap: JMP to R[n]=0xFF, then a NOP at 0xFF -> `pc` becomes 0x00.
- Reset mid-run: deassert `clb` for 2 cycles while `acc`=0x0F -> `acc`=0x00, `pc`=0x00; the program then replays identically.
- HALT: with `MCU_HALT_EN`, 0xF0 at pc 0x04 -> `pc` stays 0x04 and `acc` stays unchanged for 20 cycles. Without the macro -> `pc`=0x05.
